// File: rtl/head_lookup_arbiter.sv
// Arbitrates NUM_REQ requesters onto the single header-buffer lookup port and routes returns by tag.
// Define HEAD_ARB_RR_EN for round-robin selection; default is fixed priority (lowest index wins).
module head_lookup_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ISSUE_GAP = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [20*NUM_REQ-1:0]   req_addr,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [19:0]             addr_out,
    output logic                    addr_out_valid,
    input  logic [44:0]             type_in,
    input  logic                    type_in_valid,
    output logic [NUM_REQ-1:0]      resp_valid,
    output logic [44:0]             resp_data,
    output logic                    busy,
    output logic                    err_orphan
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

    logic [TAG_W-1:0] tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [GAP_W-1:0] gap_cnt;
    logic             full, eligible, found, accept, pop;
    logic [TAG_W-1:0] win;

    assign full     = (count == (PTR_W+1)'(TAG_DEPTH));
    // req_ready must stay low while reset is held, so reset gates eligibility directly
    assign eligible = reset && (gap_cnt == '0) && !full;
    assign accept   = eligible && found;
    assign pop      = type_in_valid && (count != '0);
    assign busy     = (count != '0);

`ifdef HEAD_ARB_RR_EN
    logic [TAG_W-1:0] rr_ptr;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = TAG_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            rr_ptr <= TAG_W'(NUM_REQ - 1);
        else if (accept)
            rr_ptr <= win;
    end
`else
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                found = 1'b1;
                win   = TAG_W'(i);
            end
        end
    end
`endif

    assign req_ready = accept ? (NUM_REQ'(1) << win) : '0;

    // Tag storage needs no reset: entries are only read behind a valid count
    always_ff @(posedge clk) begin
        if (accept)
            tag_mem[wr_ptr] <= win;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_out       <= '0;
            addr_out_valid <= 1'b0;
            resp_valid     <= '0;
            resp_data      <= '0;
            err_orphan     <= 1'b0;
            gap_cnt        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
        end else begin
            addr_out_valid <= accept;
            if (accept) begin
                addr_out <= req_addr[20*int'(win) +: 20];
                wr_ptr   <= wr_ptr + 1'b1;
                gap_cnt  <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt  <= gap_cnt - 1'b1;
            end

            resp_valid <= pop ? (NUM_REQ'(1) << tag_mem[rd_ptr]) : '0;
            if (type_in_valid)
                resp_data <= type_in;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (type_in_valid && (count == '0))
                err_orphan <= 1'b1;

            count <= count + (PTR_W+1)'(accept) - (PTR_W+1)'(pop);
        end
    end

endmodule

// File: doc/head_lookup_arbiter.md
Name: head_lookup_arbiter

Overview:
- Shares the single header-type lookup port of the header buffer (20-bit addr word in, 45-bit type word out) among NUM_REQ parser/extractor requesters.
- Grants one request at a time and enforces the minimum issue gap the buffer needs, because each lookup reads two consecutive RAM words.
- Tags every issued lookup and routes the returned type word back to the requester that issued it.
- Sits between the extractor stages and the header buffer lookup interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ISSUE_GAP, 2, minimum cycles between consecutive addr_out_valid pulses (>=1).
- TAG_DEPTH, 4, in-flight tag FIFO depth (power of 2, >= outstanding lookups possible in lookup latency).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request, held until accepted.
- req_addr  input  20*NUM_REQ  per-requester lookup word {8b state, 5b ramID, 7b byte offset}; slice i = [20*i+19:20*i].
- req_ready  output  NUM_REQ  combinational one-hot accept; transfer when req_valid[i] & req_ready[i].
- addr_out  output  20  lookup word to header buffer.
- addr_out_valid  output  1  single-cycle lookup strobe.
- type_in  input  45  returned {5b ramID, 32b type, 8b state}.
- type_in_valid  input  1  return strobe.
- resp_valid  output  NUM_REQ  one-hot, single-cycle response strobe.
- resp_data  output  45  registered copy of type_in, shared by all requesters.
- busy  output  1  tag FIFO non-empty.
- err_orphan  output  1  sticky: type_in_valid arrived with no outstanding tag.

Behaviour:
- Reset (async, reset=0): addr_out=0, addr_out_valid=0, resp_valid=0, resp_data=0, err_orphan=0, busy=0, gap counter=0, tag FIFO empty, RR pointer=NUM_REQ-1. req_ready=0 while reset is low. Lookups in flight are discarded; late type_in_valid after reset sets err_orphan.
- Grant eligibility: gap_cnt==0 AND tag FIFO not full. When eligible, exactly one req_ready bit is high: the selected requester with req_valid set. Otherwise all bits are 0.
- Selection without macro: fixed priority, lowest index wins.
- Accept at cycle t:
  - cycle t+1: addr_out = req_addr slice of the winner, addr_out_valid=1.
  - Winner index pushed to the tag FIFO at t+1.
  - gap_cnt loaded with ISSUE_GAP-1. It decrements to 0 and saturates; with ISSUE_GAP=1 back-to-back accepts are allowed.
- addr_out holds its last value when addr_out_valid=0.
- Return at cycle r (type_in_valid=1):
  - Pop the FIFO head.
  - At r+1: resp_valid[head]=1 and resp_data=type_in.
  - Responses are in order; the buffer has fixed latency of 5 cycles (addr_out_valid -> type_in_valid).
  - End-to-end: accept t -> resp_valid t+7.
- Simultaneous push and pop in the same cycle: both occur and the count is unchanged. A push while full is impossible because grants are blocked when full.
- type_in_valid with FIFO empty: no pop, no resp_valid, err_orphan<=1 (cleared only by reset).
- busy = FIFO count != 0.
- FIFO pointers are log2(TAG_DEPTH) bits and wrap modulo TAG_DEPTH. Count is log2(TAG_DEPTH)+1 bits.

Optional Feature:
- Macro HEAD_ARB_RR_EN.
- Defined: round-robin selection. Search starts at rr_ptr+1, wraps modulo NUM_REQ, and picks the first requester with req_valid set. rr_ptr updates to the winner only on accept.
- Undefined: fixed priority as in Behaviour, and no rr_ptr register exists.

Test Plan:
- Single request: req_valid[1]=1, req_addr[1]=20'h0A183 at cycle 10 -> req_ready[1]=1 at 10; addr_out=20'h0A183 with addr_out_valid at 11; buffer model returns 45'h1_2345_6789_0A at 16 -> resp_valid=4'b0010 and resp_data=45'h1_2345_6789_0A at 17.
- Contention: req_valid=4'b1011 held with ISSUE_GAP=2 -> accepts every 2 cycles. Fixed-priority order: 0,0,0... (requester 0 held). With HEAD_ARB_RR_EN: order 0,1,3,0; responses are routed to the same order 7 cycles after each accept.
- Gap enforcement: ISSUE_GAP=3, all requesters valid for 12 cycles -> addr_out_valid exactly at cycles 1,4,7,10 relative to the first accept; never closer.
- FIFO full: TAG_DEPTH=2, ISSUE_GAP=1, buffer returns delayed -> after 2 accepts req_ready=0 until the first type_in_valid; then accepts resume the next cycle; busy=1 throughout.
- Orphan: type_in_valid pulse with no outstanding lookup -> err_orphan=1, no resp_valid; remains 1 after later normal traffic until reset.
- Reset mid-operation: assert reset with 2 lookups in flight -> all outputs 0 immediately; release; a pending buffer return arrives -> err_orphan=1, resp_valid stays 0.
